// File: rtl/apb_slv_pkg.sv
// Shared types and helpers for the APB register-file completer: FSM encoding,
// WCNT index helper and the transfer error check.
package apb_slv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    // The write counter always occupies the last register slot.
    function automatic int unsigned wcnt_idx(input int unsigned num_regs);
        return num_regs - 1;
    endfunction

    function automatic logic addr_err(input logic [1:0] lsb, input logic wr, input logic hit_wcnt);
        return (lsb != 2'b00) || (wr && hit_wcnt);
    endfunction

endpackage

// File: rtl/apb_slv_wait_ctr.sv
// 4-bit loadable down-counter pacing APB wait states; done_o flags the last wait cycle.
module apb_slv_wait_ctr (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       en_i,
    output logic       done_o
);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == 4'd1);

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer with a word-addressed register file and a read-only write counter.
// Define APB_SLV_WAIT_EN to insert WAIT_CYCLES wait states per transfer.
module apb_slave_regfile
    import apb_slv_pkg::*;
#(
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned SEL_IDX     = 0,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        h_clk,
    input  logic        h_reset,
    input  logic [2:0]  p_selx,
    input  logic        p_enable,
    input  logic        p_write,
    input  logic [31:0] p_addr,
    input  logic [31:0] p_wdata,
    output logic [31:0] p_rdata,
    output logic        p_ready,
    output logic        p_slverr
);

    localparam int unsigned      IDX_W    = $clog2(NUM_REGS);
    localparam logic [IDX_W-1:0] WCNT_IDX = IDX_W'(wcnt_idx(NUM_REGS));
`ifdef APB_SLV_WAIT_EN
    localparam bit HAS_WAIT = (WAIT_CYCLES != 0);
`else
    localparam bit HAS_WAIT = 1'b0;
`endif

    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q;
    logic                     write_q, err_q;
    logic [31:0]              wdata_q;
    logic [NUM_REGS-1:0][31:0] regs_q;
    logic [31:0]              wcnt_q, rdata_q;
    logic                     ready_q, slverr_q;

    logic             sel, xfer_on, setup, from_idle, wait_done, commit, enter_acc;
    logic [IDX_W-1:0] idx_in, rd_idx;
    logic             err_in, acc_err, acc_wr;
    logic [31:0]      rd_val;
    logic             unused_ok;

    assign sel     = p_selx[SEL_IDX];
    assign xfer_on = sel & p_enable;
    assign setup   = sel & ~p_enable;
    assign idx_in  = p_addr[IDX_W+1:2];
    assign err_in  = addr_err(p_addr[1:0], p_write, idx_in == WCNT_IDX);
    assign unused_ok = ^{p_addr[31:IDX_W+2], p_selx, 32'(WAIT_CYCLES)};

`ifdef APB_SLV_WAIT_EN
    apb_slv_wait_ctr u_wait_ctr (
        .clk_i      (h_clk),
        .rst_i      (h_reset),
        .load_i     (state_q == ST_IDLE && setup),
        .load_val_i (4'(WAIT_CYCLES)),
        .en_i       (state_q == ST_WAIT),
        .done_o     (wait_done)
    );
`else
    assign wait_done = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (setup) state_d = HAS_WAIT ? ST_WAIT : ST_ACCESS;
            end
            ST_WAIT: begin
                if (!xfer_on)       state_d = ST_IDLE;
                else if (wait_done) state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                // A bridge that drops sel/enable here aborts; nothing commits.
                state_d = ST_IDLE;
                commit  = xfer_on & write_q & ~err_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ACCESS never loops on itself, so a next state of ACCESS means we are entering it.
    assign enter_acc = (state_d == ST_ACCESS);
    assign from_idle = (state_q == ST_IDLE);
    assign rd_idx    = from_idle ? idx_in  : idx_q;
    assign acc_err   = from_idle ? err_in  : err_q;
    assign acc_wr    = from_idle ? p_write : write_q;
    assign rd_val    = acc_err ? 32'd0 : ((rd_idx == WCNT_IDX) ? wcnt_q : regs_q[rd_idx]);

    always_ff @(posedge h_clk or posedge h_reset) begin
        if (h_reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= 32'd0;
            regs_q   <= '0;
            wcnt_q   <= 32'd0;
            rdata_q  <= 32'd0;
            ready_q  <= 1'b0;
            slverr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ready_q  <= enter_acc;
            slverr_q <= enter_acc & acc_err;
            if (from_idle && setup) begin
                idx_q   <= idx_in;
                write_q <= p_write;
                wdata_q <= p_wdata;
                err_q   <= err_in;
            end
            if (enter_acc && !acc_wr) rdata_q <= rd_val;
            if (commit) begin
                regs_q[idx_q] <= wdata_q;
                wcnt_q        <= wcnt_q + 32'd1;
            end
        end
    end

    assign p_rdata  = rdata_q;
    assign p_ready  = ready_q;
    assign p_slverr = slverr_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Scoreboard bench for apb_slave_regfile: a reference model pushes expected
// responses, each completed transfer pops and compares one.
module tb_apb_slave_regfile;

    localparam int SEL = 1;
`ifdef APB_SLV_WAIT_EN
    localparam int WAITS = 2;
`else
    localparam int WAITS = 0;
`endif
    localparam logic [7:0] LAT = 8'(WAITS + 1);

    typedef struct packed { logic [31:0] rdata; logic err; logic [7:0] lat; } rec_t;
    typedef struct packed { logic w; logic [31:0] a; logic [31:0] d; } op_t;

    logic        h_clk = 1'b0, h_reset = 1'b1;
    logic [2:0]  p_selx = 3'd0;
    logic        p_enable = 1'b0, p_write = 1'b0;
    logic [31:0] p_addr = 32'd0, p_wdata = 32'd0;
    logic [31:0] p_rdata;
    logic        p_ready, p_slverr;

    int   n_cmp = 0, n_bad = 0;
    rec_t exp_q[$];
    logic [31:0] m_regs [16];
    logic [31:0] m_wcnt, m_rd;

    always #5 h_clk = ~h_clk;

    apb_slave_regfile #(.NUM_REGS(16), .SEL_IDX(SEL), .WAIT_CYCLES(2)) dut (
        .h_clk(h_clk), .h_reset(h_reset), .p_selx(p_selx), .p_enable(p_enable),
        .p_write(p_write), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_rdata(p_rdata), .p_ready(p_ready), .p_slverr(p_slverr)
    );

    function automatic void model_reset();
        foreach (m_regs[i]) m_regs[i] = 32'd0;
        m_wcnt = 32'd0;
        m_rd   = 32'd0;
    endfunction

    function automatic rec_t model(input logic w, input logic [31:0] a, input logic [31:0] d);
        rec_t r;
        logic [3:0] i;
        logic e;
        i = a[5:2];
        e = (a[1:0] != 2'b00) || (w && i == 4'd15);
        if (w) begin
            if (!e) begin
                m_regs[i] = d;
                m_wcnt    = m_wcnt + 32'd1;
            end
        end else begin
            m_rd = e ? 32'd0 : ((i == 4'd15) ? m_wcnt : m_regs[i]);
        end
        r.rdata = m_rd;
        r.err   = e;
        r.lat   = LAT;
        return r;
    endfunction

    // Setup phase, then access phase with scrambled addr/data that the DUT must ignore.
    task automatic apb_do(input logic w, input logic [31:0] a, input logic [31:0] d, output rec_t obs);
        int n;
        @(negedge h_clk);
        p_selx = 3'(1 << SEL); p_enable = 1'b0; p_write = w; p_addr = a; p_wdata = d;
        @(negedge h_clk);
        p_enable = 1'b1; p_addr = ~a; p_wdata = ~d;
        n = 1;
        while (!p_ready && n < 40) begin
            @(negedge h_clk);
            n++;
        end
        obs.rdata = p_rdata;
        obs.err   = p_slverr;
        obs.lat   = p_ready ? 8'(n) : 8'hFF;
    endtask

    task automatic bus_idle();
        @(negedge h_clk);
        p_selx = 3'd0; p_enable = 1'b0;
    endtask

    task automatic test_reset();
        op_t  ops [2] = '{ {1'b0, 32'h08, 32'h0}, {1'b0, 32'h3C, 32'h0} };
        rec_t obs, ex;
        n_cmp++;
        if ({p_ready, p_slverr, p_rdata} !== 34'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got ready=%b err=%b rdata=%h want all 0", p_ready, p_slverr, p_rdata);
        end
        @(negedge h_clk);
        h_reset = 1'b0;
        foreach (ops[i]) begin
            exp_q.push_back(model(ops[i].w, ops[i].a, ops[i].d));
            apb_do(ops[i].w, ops[i].a, ops[i].d, obs);
            ex = exp_q.pop_front();
            n_cmp++;
            if (obs !== ex) begin
                n_bad++;
                $display("FAIL reset[%0d]: got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=%0d",
                         i, obs.rdata, obs.err, obs.lat, ex.rdata, ex.err, ex.lat);
            end
        end
        bus_idle();
    endtask

    task automatic test_rw();
        op_t ops [10] = '{
            {1'b1, 32'h08, 32'hDEAD_BEEF}, {1'b0, 32'h08, 32'h0}, {1'b0, 32'h3C, 32'h0},
            {1'b1, 32'h00, 32'h1111_1111}, {1'b1, 32'h38, 32'hA5A5_5A5A}, {1'b0, 32'h00, 32'h0},
            {1'b0, 32'h38, 32'h0},         {1'b1, 32'hFFFF_FF44, 32'h1234_5678},
            {1'b0, 32'h04, 32'h0},         {1'b0, 32'h3C, 32'h0} };
        rec_t obs, ex;
        foreach (ops[i]) begin
            exp_q.push_back(model(ops[i].w, ops[i].a, ops[i].d));
            apb_do(ops[i].w, ops[i].a, ops[i].d, obs);
            ex = exp_q.pop_front();
            n_cmp++;
            if (obs !== ex) begin
                n_bad++;
                $display("FAIL rw[%0d]: got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=%0d",
                         i, obs.rdata, obs.err, obs.lat, ex.rdata, ex.err, ex.lat);
            end
        end
        bus_idle();
    endtask

    task automatic test_errors();
        op_t ops [6] = '{
            {1'b1, 32'h06, 32'h0000_0001}, {1'b0, 32'h3C, 32'h0}, {1'b1, 32'h3C, 32'h0000_0005},
            {1'b0, 32'h3C, 32'h0},         {1'b0, 32'h06, 32'h0}, {1'b0, 32'h08, 32'h0} };
        rec_t obs, ex;
        foreach (ops[i]) begin
            exp_q.push_back(model(ops[i].w, ops[i].a, ops[i].d));
            apb_do(ops[i].w, ops[i].a, ops[i].d, obs);
            ex = exp_q.pop_front();
            n_cmp++;
            if (obs !== ex) begin
                n_bad++;
                $display("FAIL err[%0d]: got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=%0d",
                         i, obs.rdata, obs.err, obs.lat, ex.rdata, ex.err, ex.lat);
            end
        end
        bus_idle();
    endtask

    task automatic test_back_to_back();
        op_t ops [3] = '{ {1'b1, 32'h10, 32'h0000_00AA}, {1'b0, 32'h3C, 32'h0}, {1'b0, 32'h10, 32'h0} };
        rec_t obs, ex;
        foreach (ops[i]) begin
            exp_q.push_back(model(ops[i].w, ops[i].a, ops[i].d));
            apb_do(ops[i].w, ops[i].a, ops[i].d, obs);
            ex = exp_q.pop_front();
            n_cmp++;
            if (obs !== ex) begin
                n_bad++;
                $display("FAIL b2b[%0d]: got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=%0d",
                         i, obs.rdata, obs.err, obs.lat, ex.rdata, ex.err, ex.lat);
            end
        end
        bus_idle();
        n_cmp++;
        if (p_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL ready_width: got ready=%b one cycle after completion want 0", p_ready);
        end
    endtask

    task automatic test_abort();
        op_t  ops [2] = '{ {1'b0, 32'h00, 32'h0}, {1'b0, 32'h3C, 32'h0} };
        rec_t obs, ex;
        int   pulses = 0;
        @(negedge h_clk);
        p_selx = 3'(1 << SEL); p_enable = 1'b0; p_write = 1'b1; p_addr = 32'h00; p_wdata = 32'hCAFE_F00D;
        @(negedge h_clk);
        p_selx = 3'd0;
        repeat (6) begin
            if (p_ready) pulses++;
            @(negedge h_clk);
        end
        n_cmp++;
        if (pulses != ((WAITS > 0) ? 0 : 1)) begin
            n_bad++;
            $display("FAIL abort_ready: got %0d ready cycles want %0d", pulses, (WAITS > 0) ? 0 : 1);
        end
        foreach (ops[i]) begin
            exp_q.push_back(model(ops[i].w, ops[i].a, ops[i].d));
            apb_do(ops[i].w, ops[i].a, ops[i].d, obs);
            ex = exp_q.pop_front();
            n_cmp++;
            if (obs !== ex) begin
                n_bad++;
                $display("FAIL abort[%0d]: got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=%0d",
                         i, obs.rdata, obs.err, obs.lat, ex.rdata, ex.err, ex.lat);
            end
        end
        bus_idle();
    endtask

    task automatic test_wrap();
        op_t ops [3] = '{ {1'b0, 32'h3C, 32'h0}, {1'b1, 32'h14, 32'h0000_0042}, {1'b0, 32'h3C, 32'h0} };
        rec_t obs, ex;
        @(negedge h_clk);
        force dut.wcnt_q = 32'hFFFF_FFFF;
        @(negedge h_clk);
        release dut.wcnt_q;
        m_wcnt = 32'hFFFF_FFFF;
        foreach (ops[i]) begin
            exp_q.push_back(model(ops[i].w, ops[i].a, ops[i].d));
            apb_do(ops[i].w, ops[i].a, ops[i].d, obs);
            ex = exp_q.pop_front();
            n_cmp++;
            if (obs !== ex) begin
                n_bad++;
                $display("FAIL wrap[%0d]: got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=%0d",
                         i, obs.rdata, obs.err, obs.lat, ex.rdata, ex.err, ex.lat);
            end
        end
        bus_idle();
    endtask

    task automatic test_reset_mid();
        op_t  ops [4] = '{ {1'b0, 32'h0C, 32'h0}, {1'b0, 32'h3C, 32'h0},
                           {1'b1, 32'h0C, 32'h0000_0055}, {1'b0, 32'h0C, 32'h0} };
        rec_t obs, ex;
        int   k = 0;
        exp_q.push_back(model(1'b0, 32'h08, 32'h0));
        apb_do(1'b0, 32'h08, 32'h0, obs);
        ex = exp_q.pop_front();
        n_cmp++;
        if (obs !== ex) begin
            n_bad++;
            $display("FAIL rmid_pre: got rdata=%h want %h", obs.rdata, ex.rdata);
        end
        @(negedge h_clk);
        p_selx = 3'(1 << SEL); p_enable = 1'b0; p_write = 1'b1; p_addr = 32'h0C; p_wdata = 32'h7777_7777;
        @(negedge h_clk);
        p_enable = 1'b1;
        while (!p_ready && k < 40) begin
            @(negedge h_clk);
            k++;
        end
        h_reset = 1'b1;
        #1;
        n_cmp++;
        if ({p_ready, p_slverr, p_rdata} !== 34'd0 || k >= 40) begin
            n_bad++;
            $display("FAIL rmid_outputs: got ready=%b err=%b rdata=%h wait=%0d want all 0 within 40",
                     p_ready, p_slverr, p_rdata, k);
        end
        p_selx = 3'd0; p_enable = 1'b0;
        model_reset();
        @(negedge h_clk);
        h_reset = 1'b0;
        foreach (ops[i]) begin
            exp_q.push_back(model(ops[i].w, ops[i].a, ops[i].d));
            apb_do(ops[i].w, ops[i].a, ops[i].d, obs);
            ex = exp_q.pop_front();
            n_cmp++;
            if (obs !== ex) begin
                n_bad++;
                $display("FAIL rmid[%0d]: got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=%0d",
                         i, obs.rdata, obs.err, obs.lat, ex.rdata, ex.err, ex.lat);
            end
        end
        bus_idle();
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge h_clk);
        test_reset();
        test_rw();
        test_errors();
        test_back_to_back();
        test_abort();
        test_wrap();
        test_reset_mid();
        repeat (2) @(negedge h_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/apb_slave_regfile.md
# apb_slave_regfile

APB completer that terminates transfers issued by the AHB-to-APB bridge on one `p_selx` line. It contains a small word-addressed register file plus a read-only write-transfer counter. It drives `p_ready`, `p_rdata` and `p_slverr` with optional, parameterised wait states, and gives the bridge a real peripheral to close the loop against.

## Interface
Parameters:
- `NUM_REGS`, 16, register count including the counter register; power of two, 4..64.
- `SEL_IDX`, 0, the bit of `p_selx` that selects this slave (0..2).
- `WAIT_CYCLES`, 2, wait states inserted per transfer when `APB_SLV_WAIT_EN` is defined (0..15).

Ports:
- `h_clk`  in  1  the single clock; all state changes on its rising edge.
- `h_reset`  in  1  asynchronous reset, active-high.
- `p_selx`  in  3  slave selects from the bridge; only bit `SEL_IDX` is used.
- `p_enable`  in  1  APB access phase.
- `p_write`  in  1  1 = write, 0 = read.
- `p_addr`  in  32  byte address.
- `p_wdata`  in  32  write data.
- `p_rdata`  out  32  read data, registered.
- `p_ready`  out  1  transfer completion, registered.
- `p_slverr`  out  1  error response, valid only while `p_ready`=1.

## Operation
- `sel` = `p_selx[SEL_IDX]`.
- Index = `p_addr[log2(NUM_REGS)+1:2]`. Upper address bits are ignored (aliasing).
- Registers 0..NUM_REGS-2 are read/write, 32 bits each.
- Register NUM_REGS-1 is read-only (`WCNT`). It counts completed, error-free writes, is 32-bit and wraps from 0xFFFF_FFFF to 0.
- An error (`p_slverr`=1) occurs when `p_addr[1:0]`≠0, or on a write to `WCNT`. An erroring write changes nothing. An erroring read returns 0.
- FSM states:
  - IDLE: when `sel`=1 and `p_enable`=0, go to WAIT if the wait count is >0, else go to ACCESS. In both cases latch address, direction, data and error.
  - WAIT: down-count. When the count reaches 1, go to ACCESS.
  - ACCESS: `p_ready`=1. On the next edge go to IDLE. A write commits on this edge, and `WCNT` increments in the same edge.
- Protocol violation: if `sel` or `p_enable` falls while in WAIT or ACCESS, abort to IDLE. No write and no `WCNT` change occur. `p_ready` and `p_slverr` clear on the next edge.
- Outputs are sampled from registers latched at setup. Changes to `p_addr`/`p_wdata` during the access phase are ignored.

## Timing
- Reset values: `p_ready`=0, `p_slverr`=0, `p_rdata`=0, all registers 0, `WCNT`=0, state IDLE. Reset mid-transfer discards the transfer immediately.
- Setup cycle T0 is sampled at edge E0. With 0 waits, `p_ready`=1 during T1. With N waits, `p_ready`=1 during T1+N.
- `p_rdata` becomes valid in the same cycle `p_ready` rises. It holds its value until the next read completes; writes do not change it.
- `p_ready` is high for exactly one cycle per transfer.
- Back-to-back transfers: a setup in the cycle right after ACCESS is accepted from IDLE with no idle gap.
- A read of `WCNT` in the cycle right after a write completion returns the incremented value.

## Configuration
- `APB_SLV_WAIT_EN` defined: each transfer inserts `WAIT_CYCLES` wait states, using the WAIT state and the counter sub-module.
- `APB_SLV_WAIT_EN` undefined: WAIT state and counter are not built. `WAIT_CYCLES` is ignored and every transfer is zero-wait (`p_ready` in T1).

## Structure
- Package `apb_slv_pkg` holds:
  - state encoding: IDLE, WAIT, ACCESS;
  - `WCNT` index function/constant;
  - the error-check function.
- Sub-module `apb_slv_wait_ctr` is a 4-bit loadable down-counter with a `done` output. It is instantiated only under `APB_SLV_WAIT_EN`.

## Test plan
- Zero-wait, write then read (macro undefined):
  - write 0xDEAD_BEEF to 0x08 -> `p_ready` in T1, `p_slverr`=0;
  - read 0x08 -> `p_rdata`=0xDEAD_BEEF;
  - read 0x3C (`WCNT`, NUM_REGS=16) -> 1.
- Wait states (macro defined, WAIT_CYCLES=2): write 0x1234_5678 to 0x04 -> `p_ready` low for T1..T2, high in T3; read 0x04 returns 0x1234_5678.
- Errors:
  - write to 0x06 -> `p_slverr`=1 with `p_ready`, and `WCNT` unchanged;
  - write to 0x3C -> `p_slverr`=1, and `WCNT` unchanged;
  - read 0x06 -> `p_rdata`=0, `p_slverr`=1.
- Abort: drop `p_enable` during WAIT of a write to 0x00 -> no `p_ready` pulse; reg0 and `WCNT` unchanged.
- `WCNT` wrap: preload via 0xFFFF_FFFF completed writes (force), then one more write -> `WCNT` reads 0.
- Reset mid-transfer: assert `h_reset` during ACCESS of a write to 0x0C -> all outputs 0, reg3=0, state IDLE; the next transfer completes normally.
